// File: rtl/need_pkg.sv
// Shared types and default constants for the virtual-pet needs controller.
package need_pkg;

    typedef enum logic [1:0] {
        NEUTRAL  = 2'd0,
        HAPPY    = 2'd1,
        SAD      = 2'd2,
        CRITICAL = 2'd3
    } mood_t;

    localparam int unsigned LEVEL_W_DEF   = 3;
    localparam int unsigned LEVEL_MIN_DEF = 1;
    localparam int unsigned LEVEL_MAX_DEF = 5;
    localparam int unsigned HOLD_W        = 8;
    localparam int unsigned DECAY_W       = 12;

    // Fun-activity coupling: sustained play on the source drains the destination.
    localparam int unsigned COUPLE_SRC    = 2;
    localparam int unsigned COUPLE_DST    = 3;
    localparam int unsigned COUPLE_TICKS  = 30;

endpackage

// File: rtl/need_channel.sv
// One need channel: press-to-increment hold counter, periodic decay counter
// and saturating level register with an external drain request.
module need_channel
    import need_pkg::*;
#(
    parameter int unsigned        LEVEL_W    = LEVEL_W_DEF,
    parameter int unsigned        LEVEL_MIN  = LEVEL_MIN_DEF,
    parameter int unsigned        LEVEL_MAX  = LEVEL_MAX_DEF,
    parameter int unsigned        LEVEL_INIT = 3,
    parameter logic [HOLD_W-1:0]  HOLD       = HOLD_W'(10),
    parameter logic [DECAY_W-1:0] DECAY      = DECAY_W'(900),
    parameter int unsigned        ACC_STEP   = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic               i_acc,
    input  logic               i_stim,
    input  logic               i_drain,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_alarm,
    output logic               o_inc_pulse
);

    localparam int unsigned        SUM_W = DECAY_W + 1;
    localparam logic [LEVEL_W-1:0] LMIN  = LEVEL_W'(LEVEL_MIN);
    localparam logic [LEVEL_W-1:0] LMAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LINIT = LEVEL_W'(LEVEL_INIT);
    localparam logic [SUM_W-1:0]   STEP  = SUM_W'(ACC_STEP);
    localparam logic [SUM_W-1:0]   PER   = SUM_W'(DECAY);

    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_armed;
    logic [DECAY_W-1:0] r_decay_cnt;
    logic [LEVEL_W-1:0] r_level;
    logic               r_alarm;
    logic               r_inc;

    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [SUM_W-1:0]   w_decay_sum;
    logic               w_decay_hit;
    logic               w_inc;
    logic               w_dec;
    logic [LEVEL_W-1:0] w_level_nxt;

    // Simultaneous increment and decrement cancel; both saturate.
    always_comb begin
        w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
        w_inc       = i_tick && i_stim && r_armed && (w_hold_nxt == HOLD);
        w_decay_sum = {1'b0, r_decay_cnt} + (i_acc ? STEP : SUM_W'(1));
        w_decay_hit = i_tick && (w_decay_sum >= PER);
        w_dec       = w_decay_hit || i_drain;
        w_level_nxt = r_level;
        if (w_inc && !w_dec && (r_level < LMAX)) begin
            w_level_nxt = r_level + LEVEL_W'(1);
        end else if (w_dec && !w_inc && (r_level > LMIN)) begin
            w_level_nxt = r_level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_armed     <= 1'b1;
            r_decay_cnt <= '0;
            r_level     <= LINIT;
            r_alarm     <= (LINIT == LMIN);
            r_inc       <= 1'b0;
        end else begin
            r_inc   <= w_inc;
            r_level <= w_level_nxt;
            r_alarm <= (w_level_nxt == LMIN);
            // Releasing the stimulus on any clock re-arms the next press.
            if (!i_stim) begin
                r_armed    <= 1'b1;
                r_hold_cnt <= '0;
            end else if (i_tick && r_armed) begin
                if (w_inc) begin
                    r_hold_cnt <= '0;
                    r_armed    <= 1'b0;
                end else begin
                    r_hold_cnt <= w_hold_nxt;
                end
            end
            if (i_tick) begin
                r_decay_cnt <= w_decay_hit ? DECAY_W'(w_decay_sum - PER)
                                           : DECAY_W'(w_decay_sum);
            end
        end
    end

    assign o_level     = r_level;
    assign o_alarm     = r_alarm;
    assign o_inc_pulse = r_inc;

endmodule

// File: rtl/need_engine.sv
// Needs controller: NUM_NEEDS need channels plus a registered mood FSM.
// Define NEED_ENGINE_COUPLE_EN to compile in the fun-activity energy drain.
module need_engine
    import need_pkg::*;
#(
    parameter int unsigned                  NUM_NEEDS  = 4,
    parameter int unsigned                  LEVEL_W    = LEVEL_W_DEF,
    parameter int unsigned                  LEVEL_MIN  = LEVEL_MIN_DEF,
    parameter int unsigned                  LEVEL_MAX  = LEVEL_MAX_DEF,
    parameter int unsigned                  LEVEL_INIT = 3,
    parameter logic [NUM_NEEDS*HOLD_W-1:0]  HOLD_TICKS = {8'd10, 8'd15, 8'd3, 8'd10},
    parameter logic [NUM_NEEDS*DECAY_W-1:0] DECAY_SEC  = {12'd900, 12'd900, 12'd3600, 12'd1800},
    parameter int unsigned                  ACC_STEP   = 30,
    parameter int unsigned                  HAPPY_LVL  = 4,
    parameter int unsigned                  CRIT_SEC   = 60
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_tick,
    input  logic                         i_acc,
    input  logic [NUM_NEEDS-1:0]         i_stim,
    output logic [NUM_NEEDS*LEVEL_W-1:0] o_level,
    output logic [NUM_NEEDS-1:0]         o_alarm,
    output logic [1:0]                   o_mood,
    output logic [NUM_NEEDS-1:0]         o_inc_pulse
);

    localparam int unsigned         CRIT_W    = $clog2(CRIT_SEC + 1);
    localparam logic [CRIT_W-1:0]   CRIT_LAST = CRIT_W'(CRIT_SEC - 1);
    localparam logic [CRIT_W-1:0]   CRIT_TOP  = CRIT_W'(CRIT_SEC);
    localparam logic [LEVEL_W-1:0]  LHAPPY    = LEVEL_W'(HAPPY_LVL);

    logic [NUM_NEEDS-1:0] w_drain;
    logic                 w_any_alarm;
    logic                 w_all_happy;
    logic [CRIT_W-1:0]    r_crit_cnt;
    mood_t                r_mood;

    for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_ch
        need_channel #(
            .LEVEL_W    (LEVEL_W),
            .LEVEL_MIN  (LEVEL_MIN),
            .LEVEL_MAX  (LEVEL_MAX),
            .LEVEL_INIT (LEVEL_INIT),
            .HOLD       (HOLD_TICKS[g*HOLD_W +: HOLD_W]),
            .DECAY      (DECAY_SEC[g*DECAY_W +: DECAY_W]),
            .ACC_STEP   (ACC_STEP)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_tick      (i_tick),
            .i_acc       (i_acc),
            .i_stim      (i_stim[g]),
            .i_drain     (w_drain[g]),
            .o_level     (o_level[g*LEVEL_W +: LEVEL_W]),
            .o_alarm     (o_alarm[g]),
            .o_inc_pulse (o_inc_pulse[g])
        );
    end

`ifdef NEED_ENGINE_COUPLE_EN
    localparam int unsigned CPL_W = $clog2(COUPLE_TICKS + 1);

    logic [CPL_W-1:0] r_cpl_cnt;
    logic             r_cpl_armed;
    logic             w_cpl_fire;

    // One drain per continuous press of the source channel.
    always_comb begin
        w_cpl_fire = i_tick && i_stim[COUPLE_SRC] && r_cpl_armed
                     && (r_cpl_cnt == CPL_W'(COUPLE_TICKS - 1));
        w_drain    = NUM_NEEDS'(w_cpl_fire) << COUPLE_DST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpl_cnt   <= '0;
            r_cpl_armed <= 1'b1;
        end else if (!i_stim[COUPLE_SRC]) begin
            r_cpl_cnt   <= '0;
            r_cpl_armed <= 1'b1;
        end else if (i_tick && r_cpl_armed) begin
            if (w_cpl_fire) begin
                r_cpl_cnt   <= '0;
                r_cpl_armed <= 1'b0;
            end else begin
                r_cpl_cnt <= r_cpl_cnt + CPL_W'(1);
            end
        end
    end
`else
    assign w_drain = '0;
`endif

    always_comb begin
        w_any_alarm = |o_alarm;
        w_all_happy = 1'b1;
        for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
            if (o_level[i*LEVEL_W +: LEVEL_W] < LHAPPY) begin
                w_all_happy = 1'b0;
            end
        end
    end

    // Mood follows the registered levels; CRITICAL latches until alarms clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mood     <= NEUTRAL;
            r_crit_cnt <= '0;
        end else if (!w_any_alarm) begin
            r_crit_cnt <= '0;
            r_mood     <= w_all_happy ? HAPPY : NEUTRAL;
        end else begin
            if (i_tick && (r_crit_cnt != CRIT_TOP)) begin
                r_crit_cnt <= r_crit_cnt + CRIT_W'(1);
            end
            case (r_mood)
                CRITICAL: r_mood <= CRITICAL;
                default:  r_mood <= (i_tick && (r_crit_cnt == CRIT_LAST)) ? CRITICAL : SAD;
            endcase
        end
    end

    assign o_mood = r_mood;

endmodule

// File: tb/tb_need_engine.sv
// Directed bench for need_engine with a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_need_engine;

    localparam int N  = 4;
    localparam int LW = 3;
`ifdef NEED_ENGINE_COUPLE_EN
    localparam int CPL_LVL = 3;
`else
    localparam int CPL_LVL = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          acc = 1'b0;
    logic [N-1:0]  stim = '0;
    logic [N*LW-1:0] o_level;
    logic [N-1:0]  o_alarm;
    logic [1:0]    o_mood;
    logic [N-1:0]  o_inc_pulse;

    need_engine u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (tick),
        .i_acc       (acc),
        .i_stim      (stim),
        .o_level     (o_level),
        .o_alarm     (o_alarm),
        .o_mood      (o_mood),
        .o_inc_pulse (o_inc_pulse)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: per-channel integers stepped on each clock edge.
    int hold_t [N] = '{10, 3, 15, 10};
    int decay_t[N] = '{1800, 3600, 900, 900};
    int m_lvl[N], m_hc[N], m_dc[N];
    bit m_arm[N], m_alarm[N], m_pulse[N];
    int m_mood, m_crit, m_cpl_cnt;
    bit m_cpl_arm;
    bit any_a, all_h, inc_now, dec_now, drain3;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_lvl[i] = 3; m_hc[i] = 0; m_dc[i] = 0;
                m_arm[i] = 1; m_alarm[i] = 0; m_pulse[i] = 0;
            end
            m_mood = 0; m_crit = 0; m_cpl_cnt = 0; m_cpl_arm = 1;
        end else begin
            any_a = 0; all_h = 1;
            for (int i = 0; i < N; i++) begin
                if (m_alarm[i]) any_a = 1;
                if (m_lvl[i] < 4) all_h = 0;
            end
            if (!any_a) begin
                m_crit = 0;
                m_mood = all_h ? 1 : 0;
            end else begin
                if (tick) m_crit++;
                m_mood = (m_mood == 3 || m_crit >= 60) ? 3 : 2;
            end
            drain3 = 0;
`ifdef NEED_ENGINE_COUPLE_EN
            if (!stim[2]) begin
                m_cpl_arm = 1; m_cpl_cnt = 0;
            end else if (tick && m_cpl_arm) begin
                m_cpl_cnt++;
                if (m_cpl_cnt == 30) begin drain3 = 1; m_cpl_cnt = 0; m_cpl_arm = 0; end
            end
`endif
            for (int i = 0; i < N; i++) begin
                inc_now = 0; dec_now = (i == 3) && drain3;
                if (!stim[i]) begin
                    m_arm[i] = 1; m_hc[i] = 0;
                end else if (tick && m_arm[i]) begin
                    m_hc[i]++;
                    if (m_hc[i] == hold_t[i]) begin inc_now = 1; m_hc[i] = 0; m_arm[i] = 0; end
                end
                if (tick) begin
                    m_dc[i] += acc ? 30 : 1;
                    if (m_dc[i] >= decay_t[i]) begin m_dc[i] -= decay_t[i]; dec_now = 1; end
                end
                if (inc_now && !dec_now && m_lvl[i] < 5) m_lvl[i]++;
                if (dec_now && !inc_now && m_lvl[i] > 1) m_lvl[i]--;
                m_pulse[i] = inc_now;
                m_alarm[i] = (m_lvl[i] == 1);
            end
        end
    end

    logic [N*LW-1:0] e_level;
    logic [N-1:0]    e_alarm, e_pulse;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int i = 0; i < N; i++) begin
                e_level[i*LW +: LW] = LW'(m_lvl[i]);
                e_alarm[i] = m_alarm[i];
                e_pulse[i] = m_pulse[i];
            end
            check("model_level", 32'(o_level), 32'(e_level));
            check("model_alarm", 32'(o_alarm), 32'(e_alarm));
            check("model_pulse", 32'(o_inc_pulse), 32'(e_pulse));
            check("model_mood", 32'(o_mood), 32'(m_mood));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each tick is a one-cycle strobe followed by one quiet cycle.
    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_level", 32'(o_level), 32'h6DB);
        check("rst_alarm", 32'(o_alarm), 0);
        check("rst_mood", 32'(o_mood), 0);
        check("rst_pulse", 32'(o_inc_pulse), 0);

        // Single increment per press, then saturation at the ceiling.
        stim = 4'b0001;
        tick_n(9);
        check("hold9_lvl0", 32'(o_level[2:0]), 3);
        tick_n(1);
        check("hold10_lvl0", 32'(o_level[2:0]), 4);
        check("hold10_pulse0", 32'(o_inc_pulse[0]), 1);
        tick_n(15);
        check("hold25_lvl0", 32'(o_level[2:0]), 4);
        stim[0] = 1'b0; idle(1); stim[0] = 1'b1;
        tick_n(10);
        check("press2_lvl0", 32'(o_level[2:0]), 5);
        stim[0] = 1'b0; idle(1); stim[0] = 1'b1;
        tick_n(10);
        check("sat_lvl0", 32'(o_level[2:0]), 5);
        check("sat_pulse0", 32'(o_inc_pulse[0]), 1);
        stim = '0;

        // Reset mid-hold discards the partial count.
        stim[1] = 1'b1;
        tick_n(2);
        do_reset();
        check("midrst_level", 32'(o_level), 32'h6DB);
        tick_n(2);
        check("midrst_lvl1", 32'(o_level[5:3]), 3);
        tick_n(1);
        check("midrst_inc1", 32'(o_level[5:3]), 4);
        check("midrst_pulse1", 32'(o_inc_pulse), 32'b0010);
        stim = '0;

        // Accelerated decay into alarm, SAD, CRITICAL; coincident inc/dec on ch1.
        do_reset();
        acc = 1'b1;
        tick_n(117);
        check("acc117_alarm", 32'(o_alarm), 32'b1100);
        check("acc117_mood", 32'(o_mood), 2);
        stim[1] = 1'b1;
        tick_n(3);
        check("acc120_level", 32'(o_level), 32'h259);
        check("acc120_alarm", 32'(o_alarm), 32'b1101);
        check("acc120_pulse", 32'(o_inc_pulse), 32'b0010);
        idle(1);
        check("acc120_mood", 32'(o_mood), 3);
        stim = '0;
        acc = 1'b0;

        // Recovery from CRITICAL needs every alarm cleared.
        stim = 4'b1101;
        tick_n(10);
        check("rec10_lvl0", 32'(o_level[2:0]), 2);
        check("rec10_alarm", 32'(o_alarm), 32'b0100);
        idle(1);
        check("rec10_mood", 32'(o_mood), 3);
        tick_n(5);
        check("rec15_alarm", 32'(o_alarm), 0);
        idle(1);
        check("rec15_mood", 32'(o_mood), 0);
        stim = '0; idle(1); stim = 4'hF;
        tick_n(15);
        stim = '0; idle(1); stim = 4'hF;
        tick_n(15);
        stim = '0;
        check("happy_level", 32'(o_level), 32'h92C);
        idle(1);
        check("happy_mood", 32'(o_mood), 1);

        // Sustained play on channel 2 against channel 3.
        idle(1);
        stim = 4'b0100;
        tick_n(29);
        check("cpl29_lvl3", 32'(o_level[11:9]), 4);
        check("cpl29_lvl2", 32'(o_level[8:6]), 5);
        tick_n(1);
        check("cpl30_lvl3", 32'(o_level[11:9]), CPL_LVL);
        tick_n(30);
        check("cpl60_lvl3", 32'(o_level[11:9]), CPL_LVL);
        stim = '0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
